// File: rtl/lcd_mode_pkg.sv
// lcd_mode_pkg: shared FSM states, HD44780 command bytes and byte encoders
package lcd_mode_pkg;
  typedef enum logic [2:0] {POWERUP, INIT_ISSUE, IDLE, SETUP, PULSE, HOLD} state_t;
  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] DISP_OFF = 8'h08;
  localparam logic [7:0] CLEAR = 8'h01;
  localparam logic [7:0] HOME = 8'h02;
  localparam logic [7:0] ENTRY_INC = 8'h06;
  localparam logic [7:0] DISP_CTRL_BASE = 8'h08;
  localparam logic [2:0] INIT_LEN = 3'd7;
  function automatic logic [7:0] disp_ctrl(input logic [1:0] m);
    return DISP_CTRL_BASE | {5'd0, m[0], m[1], 1'b0};
  endfunction
  function automatic logic [7:0] init_byte(input logic [2:0] i, input logic [1:0] m);
    return (i < 3'd3) ? FUNC_SET_8B2L : (i == 3'd3) ? DISP_OFF : (i == 3'd4) ? CLEAR :
           (i == 3'd5) ? ENTRY_INC : disp_ctrl(m);
  endfunction
  function automatic logic long_wait(input logic rs, input logic [7:0] d);
    return !rs && (d == CLEAR || d == HOME);
  endfunction
endpackage

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: one LCD bus write (setup, E pulse, hold); the same counter also
// times the power-up delay out of reset.
module lcd_byte_writer
  import lcd_mode_pkg::*;
#(
  parameter int POWERUP_CYC = 750000,
  parameter int SETUP_CYC = 4,
  parameter int E_PULSE_CYC = 25,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  input  logic       long_wait_i,
  output logic       done_o,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic [7:0] lcd_data_o
);
  localparam int M1 = (POWERUP_CYC > SETUP_CYC) ? POWERUP_CYC : SETUP_CYC;
  localparam int M2 = (M1 > E_PULSE_CYC) ? M1 : E_PULSE_CYC;
  localparam int M3 = (M2 > CMD_WAIT_CYC) ? M2 : CMD_WAIT_CYC;
  localparam int MAX_CYC = (M3 > CLEAR_WAIT_CYC) ? M3 : CLEAR_WAIT_CYC;
  localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] PU_N = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] SU_N = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EP_N = CW'(E_PULSE_CYC - 1);
  localparam logic [CW-1:0] CMD_N = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLR_N = CW'(CLEAR_WAIT_CYC - 1);
  state_t phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rs_q, rs_d, long_q, long_d;
  logic [7:0] data_q, data_d;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      phase_q <= POWERUP;
      cnt_q <= PU_N;
      rs_q <= 1'b0;
      long_q <= 1'b0;
      data_q <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      rs_q <= rs_d;
      long_q <= long_d;
      data_q <= data_d;
    end
  end
  // Each phase loads N-1 on entry and advances when the counter hits zero.
  always_comb begin
    phase_d = phase_q;
    cnt_d = cnt_q - CW'(1);
    rs_d = rs_q;
    data_d = data_q;
    long_d = long_q;
    done_o = 1'b0;
    if (phase_q == IDLE) begin
      cnt_d = '0;
      if (start_i) begin
        phase_d = SETUP;
        cnt_d = SU_N;
        rs_d = rs_i;
        data_d = data_i;
        long_d = long_wait_i;
      end
    end else if (cnt_q == '0) begin
      phase_d = (phase_q == SETUP) ? PULSE : (phase_q == PULSE) ? HOLD : IDLE;
      cnt_d = (phase_q == SETUP) ? EP_N : (phase_q == PULSE) ? (long_q ? CLR_N : CMD_N) : '0;
      done_o = (phase_q == HOLD) || (phase_q == POWERUP);
    end
  end
  assign lcd_e_o = phase_q == PULSE;
  assign lcd_rs_o = rs_q;
  assign lcd_data_o = data_q;
endmodule

// File: rtl/lcd_mode_sequencer.sv
// lcd_mode_sequencer: HD44780 power-up init, requester byte writes and
// translation of mode-register changes into display-control commands.
module lcd_mode_sequencer
  import lcd_mode_pkg::*;
#(
  parameter int POWERUP_CYC = 750000,
  parameter int SETUP_CYC = 4,
  parameter int E_PULSE_CYC = 25,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] mode_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rs_i,
  input  logic [7:0] req_data_i,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic [7:0] lcd_data_o,
  output logic       busy_o,
  output logic       init_done_o
);
  state_t ctl_q, ctl_d;
  logic wr_q, wr_d, init_done_q, init_done_d;
  logic [2:0] idx_q, idx_d;
  logic [1:0] mode_q, mode_d;
  logic done, start, rs, free, pending;
  logic [7:0] data;
  assign pending = mode_i != mode_q;
  assign free = (ctl_q == IDLE) && !wr_q;
  assign req_ready_o = free && init_done_q && !pending;
  assign busy_o = !free;
  assign lcd_rw_o = 1'b0;
  assign init_done_o = init_done_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ctl_q <= POWERUP;
      wr_q <= 1'b0;
      idx_q <= '0;
      mode_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      ctl_q <= ctl_d;
      wr_q <= wr_d;
      idx_q <= idx_d;
      mode_q <= mode_d;
      init_done_q <= init_done_d;
    end
  end
  // A pending mode change always beats a waiting request.
  always_comb begin
    ctl_d = ctl_q;
    wr_d = wr_q && !done;
    idx_d = idx_q;
    mode_d = mode_q;
    init_done_d = init_done_q;
    start = 1'b0;
    rs = 1'b0;
    data = disp_ctrl(mode_i);
    if (ctl_q == INIT_ISSUE && !wr_q) begin
      start = 1'b1;
      data = init_byte(idx_q, mode_i);
      idx_d = idx_q + 3'd1;
      if (idx_q == INIT_LEN - 3'd1) mode_d = mode_i;
    end else if (free && pending) begin
      start = 1'b1;
      mode_d = mode_i;
    end else if (req_ready_o && req_valid_i) begin
      start = 1'b1;
      rs = req_rs_i;
      data = req_data_i;
    end
    if (start) wr_d = 1'b1;
    if (done && ctl_q == POWERUP) ctl_d = INIT_ISSUE;
    if (done && ctl_q == INIT_ISSUE && idx_q == INIT_LEN) begin
      ctl_d = IDLE;
      init_done_d = 1'b1;
    end
  end
  lcd_byte_writer #(
    .POWERUP_CYC(POWERUP_CYC),
    .SETUP_CYC(SETUP_CYC),
    .E_PULSE_CYC(E_PULSE_CYC),
    .CMD_WAIT_CYC(CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC)
  ) u_writer (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .start_i(start),
    .rs_i(rs),
    .data_i(data),
    .long_wait_i(long_wait(rs, data)),
    .done_o(done),
    .lcd_e_o(lcd_e_o),
    .lcd_rs_o(lcd_rs_o),
    .lcd_data_o(lcd_data_o)
  );
endmodule
